// File: rtl/bitcount_unit.sv
// Multi-cycle CPOP/CLZ/CTZ unit: examines CHUNK bits of the latched operand per cycle.
// Optional BITCOUNT_EARLY_EXIT_EN finishes as soon as the remaining chunks cannot change the result.
module bitcount_unit #(
  parameter int XLEN = 32,
  parameter int CHUNK = 8,
  localparam int RW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_result,
  output logic            busy
);

  localparam int NCH = XLEN / CHUNK;
  localparam int CW  = $clog2(CHUNK) + 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] OP_CPOP = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] x_reg;
  logic [1:0]      op_reg;
  logic [RW-1:0]   acc_reg, acc_next;
  logic [IW-1:0]   idx_reg;
  logic            found_reg, found_next;

  logic [CHUNK-1:0] chunk;
  logic [XLEN-1:0]  x_shifted;
  logic [CW-1:0]    chunk_cnt;
  logic             chunk_nz;
  logic             last_chunk;
  logic             finish;

  function automatic logic [CW-1:0] f_pop(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      n = n + CW'(c[i]);
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] f_lz(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          seen;
    n    = '0;
    seen = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) seen = 1'b1;
      else if (!seen) n = n + CW'(1);
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] f_tz(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          seen;
    n    = '0;
    seen = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) seen = 1'b1;
      else if (!seen) n = n + CW'(1);
    end
    return n;
  endfunction

  // The operand is consumed by shifting: CLZ walks from the MSB end, the others from the LSB end.
  always_comb begin
    chunk     = x_reg[CHUNK-1:0];
    x_shifted = x_reg >> CHUNK;
    if (op_reg == OP_CLZ) begin
      chunk     = x_reg[XLEN-1 -: CHUNK];
      x_shifted = x_reg << CHUNK;
    end
    chunk_nz = |chunk;

    chunk_cnt = '0;
    case (op_reg)
      OP_CPOP: chunk_cnt = f_pop(chunk);
      OP_CLZ:  chunk_cnt = f_lz(chunk);
      OP_CTZ:  chunk_cnt = f_tz(chunk);
      default: chunk_cnt = '0;
    endcase

    acc_next   = acc_reg;
    found_next = found_reg;
    case (op_reg)
      OP_CPOP: acc_next = acc_reg + RW'(chunk_cnt);
      OP_CLZ, OP_CTZ: begin
        if (!found_reg) begin
          acc_next   = acc_reg + RW'(chunk_cnt);
          found_next = chunk_nz;
        end
      end
      default: acc_next = acc_reg;
    endcase
  end

  always_comb begin
    last_chunk = (idx_reg == IW'(NCH - 1));
`ifdef BITCOUNT_EARLY_EXIT_EN
    case (op_reg)
      OP_CPOP:        finish = last_chunk || (x_shifted == '0);
      OP_CLZ, OP_CTZ: finish = last_chunk || chunk_nz;
      default:        finish = 1'b1;
    endcase
`else
    finish = last_chunk;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (in_valid) state_next = BUSY;
        BUSY:    if (finish) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      found_reg <= 1'b0;
    end else if (!flush) begin
      if (state_reg == IDLE && in_valid) begin
        x_reg     <= in_x;
        op_reg    <= in_op;
        acc_reg   <= '0;
        idx_reg   <= '0;
        found_reg <= 1'b0;
      end else if (state_reg == BUSY) begin
        x_reg     <= x_shifted;
        acc_reg   <= acc_next;
        found_reg <= found_next;
        idx_reg   <= idx_reg + IW'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    in_ready   = (state_reg == IDLE);
    busy       = (state_reg == BUSY) || (state_reg == DONE);
    out_valid  = (state_reg == DONE);
    out_result = (state_reg == DONE) ? acc_reg : '0;
  end

endmodule

// File: tb/tb_bitcount_unit.sv
// Directed self-checking bench for bitcount_unit (XLEN=32, CHUNK=8).
module tb_bitcount_unit;

  localparam int XLEN = 32;
  localparam int RW   = 6;
  localparam int NCH  = 4;
`ifdef BITCOUNT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_x;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_result;
  logic            busy;

  int checks = 0;
  int failures = 0;

  bitcount_unit #(.XLEN(XLEN), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present one operand at a negedge; returns #1 after the acceptance edge with inputs scrambled.
  task automatic accept(input logic [1:0] op, input logic [31:0] x);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_x     = ~x;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                        input int exp_res, input int lat_fixed, input int lat_early);
    int lat;
    int exp_lat;
    exp_lat = EARLY ? lat_early : lat_fixed;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_idle_ready"}, in_ready, 1);
    accept(op, x);
    check_eq({tag, "_busy"}, busy, 1);
    wait_valid(lat);
    $display("op=%0d x=%08h result=%0d latency=%0d", op, x, out_result, lat);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_result"}, out_result, exp_res);
    check_eq({tag, "_in_ready_done"}, in_ready, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid_drop"}, out_valid, 0);
    check_eq({tag, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_x = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", out_result, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("cpop_mixed", 2'b00, 32'hF0F0_0001, 9, 4, 4);
    run_op("clz_bit16", 2'b01, 32'h0001_0000, 15, 4, 2);
    run_op("ctz_bit16", 2'b10, 32'h0001_0000, 16, 4, 3);
    run_op("clz_zero", 2'b01, 32'h0000_0000, 32, 4, 4);
    run_op("ctz_zero", 2'b10, 32'h0000_0000, 32, 4, 4);
    run_op("cpop_ones", 2'b00, 32'hFFFF_FFFF, 32, 4, 4);
    run_op("clz_ones", 2'b01, 32'hFFFF_FFFF, 0, 4, 1);
    run_op("ctz_ones", 2'b10, 32'hFFFF_FFFF, 0, 4, 1);
    run_op("op_rsvd", 2'b11, 32'h1234_5678, 0, 4, 1);
    run_op("cpop_zero", 2'b00, 32'h0000_0000, 0, 4, 1);

    // Backpressure: result must hold while out_ready is low, and new requests are refused.
    out_ready = 1'b0;
    accept(2'b10, 32'h8000_0000);
    wait_valid(lat);
    check_eq("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid_hold", out_valid, 1);
      check_eq("bp_result_hold", out_result, 31);
      check_eq("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_x     = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("op=2 x=80000000 backpressure released");
    check_eq("bp_release_valid", out_valid, 0);
    check_eq("bp_release_ready", in_ready, 1);
    check_eq("bp_no_accept", busy, 0);

    // Flush on the second BUSY cycle of a CPOP
    accept(2'b00, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_busy_ready", in_ready, 1);
    check_eq("flush_busy_busy", busy, 0);
    seen = 0;
    repeat (NCH + 2) begin
      if (out_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    $display("op=0 x=ffffffff flushed in BUSY");
    check_eq("flush_no_valid", seen, 0);
    run_op("clz_after_flush", 2'b01, 32'h0000_00FF, 24, 4, 4);

    // Flush together with in_valid in IDLE: must not accept
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_x = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    $display("flush with in_valid in IDLE");
    check_eq("flush_idle_busy", busy, 0);
    check_eq("flush_idle_ready", in_ready, 1);

    // Flush in DONE with out_ready high: result discarded
    out_ready = 1'b0;
    accept(2'b00, 32'h0000_00FF);
    wait_valid(lat);
    check_eq("flush_done_result", out_result, 8);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    $display("op=0 x=000000ff flushed in DONE");
    check_eq("flush_done_valid", out_valid, 0);
    check_eq("flush_done_ready", in_ready, 1);

    // Asynchronous reset between edges, mid-BUSY
    accept(2'b00, 32'hF0F0_0001);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    $display("rst pulse mid-BUSY");
    check_eq("arst_busy_ready", in_ready, 1);
    check_eq("arst_busy_busy", busy, 0);
    check_eq("arst_busy_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("ctz_after_rst", 2'b10, 32'h0000_0100, 8, 4, 2);

    // Asynchronous reset while a result is held in DONE
    out_ready = 1'b0;
    accept(2'b10, 32'h8000_0000);
    wait_valid(lat);
    check_eq("arst_done_pre", out_result, 31);
    #2;
    rst = 1'b1;
    #1;
    $display("rst pulse in DONE");
    check_eq("arst_done_valid", out_valid, 0);
    check_eq("arst_done_result", out_result, 0);
    check_eq("arst_done_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("cpop_after_rst", 2'b00, 32'hF0F0_0001, 9, 4, 4);

    run_op("ctz_lsb", 2'b10, 32'h0000_0001, 0, 4, 1);
    run_op("cpop_three", 2'b00, 32'h0000_0003, 2, 4, 1);
    run_op("clz_lsb", 2'b01, 32'h0000_0001, 31, 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitcount_unit.md
Name: bitcount_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle population counter in the execute stage.
- Serves the Zbb count instructions CPOP, CLZ and CTZ over a configurable operand width.
- Consumes CHUNK bits per cycle behind a valid/ready handshake, trading latency for area.
- Sits beside the ALU; the pipeline stalls on in_ready/out_valid and can kill an in-flight operation with flush.

Parameters:
XLEN, 32, operand width; power of two, at least 8.
CHUNK, 8, bits examined per cycle; power of two, divides XLEN, at most XLEN.
(derived) NCH = XLEN/CHUNK; RW = $clog2(XLEN)+1.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active high.
flush  in  1  synchronous abort of any operation in progress.
in_valid  in  1  operand and op are presented.
in_ready  out  1  unit can accept; equals (state==IDLE).
in_op  in  2  operation: 00 CPOP, 01 CLZ, 10 CTZ, 11 reserved.
in_x  in  XLEN  operand.
out_valid  out  1  result is available.
out_ready  in  1  consumer takes the result.
out_result  out  RW  count, zero-extended by the consumer.
busy  out  1  state is BUSY or DONE.

Behaviour:
- Reset (async, rst=1): state IDLE, out_valid=0, out_result=0, busy=0, in_ready=1, internal accumulator/index/found flag cleared. Reset mid-operation discards the operation.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_valid&&in_ready at edge N latches in_x and in_op, clears the accumulator, chunk index k=0 and the found flag, then goes to BUSY.
- BUSY: one chunk per edge.
  - CPOP: acc += popcount of chunk k, taken from the LSB side.
  - CLZ: chunks taken from the MSB side. If found=0, acc += leading zeros of the chunk. found is set when the chunk is nonzero. Once found=1, acc is frozen.
  - CTZ: mirror of CLZ, taken from the LSB side, counting trailing zeros.
  - Op 11: acc stays 0.
  - After chunk NCH-1 is processed, go to DONE.
- Latency: out_valid rises exactly NCH cycles after the acceptance edge (default 4).
- DONE: out_valid=1 and out_result=acc, both held stable until out_ready=1. At that edge go to IDLE and drop out_valid. in_ready=0 in DONE; there is no same-cycle re-accept. Minimum issue interval is NCH+2 cycles.
- Width rules: acc is RW bits and never overflows; maximum value is XLEN. All-zero operand gives XLEN for CLZ and CTZ and 0 for CPOP. All-ones operand gives XLEN for CPOP and 0 for CLZ and CTZ.
- flush: highest priority after rst.
  - In BUSY or DONE: go to IDLE at the next edge; out_valid=0 from that edge. The result is lost even if out_ready=1 in the same cycle.
  - flush with in_valid in IDLE: the input is not accepted.
- in_op and in_x may change freely after acceptance; only the latched copy is used.
- Changing out_ready while out_valid=0 has no effect.

Optional Feature:
Macro BITCOUNT_EARLY_EXIT_EN.
- Defined:
  - CLZ/CTZ go to DONE at the edge that processes the first nonzero chunk.
  - CPOP goes to DONE once the remaining unprocessed bits of the latched operand are all zero.
  - Op 11 goes to DONE after one cycle.
  - Latency is variable, from 1 to NCH cycles; results are identical to the non-early-exit build.
- Undefined: fixed latency of NCH cycles for every op.

Test Plan:
- CPOP, in_x=32'hF0F0_0001, out_ready=1 -> out_valid exactly 4 cycles after accept, out_result=9, back to IDLE the next cycle.
- CLZ 32'h0001_0000 -> 15; CTZ 32'h0001_0000 -> 16; CLZ 0 -> 32; CTZ 0 -> 32; CPOP 32'hFFFF_FFFF -> 32; op 11 -> 0.
- Backpressure: CTZ 32'h8000_0000, out_ready held low 5 cycles after out_valid -> out_valid and out_result=31 held stable, in_ready=0 throughout; released on the out_ready edge.
- flush asserted on the second BUSY cycle of a CPOP -> IDLE next edge, out_valid never rises. A following CLZ 32'h0000_00FF is accepted and returns 24.
- rst pulsed mid-BUSY, including a pulse between clock edges -> outputs at reset values immediately, in_ready=1. The next operation is correct.
- With BITCOUNT_EARLY_EXIT_EN: CTZ 32'h0000_0001 -> out_valid 1 cycle after accept, result 0. CPOP 32'h0000_0003 -> 1 cycle, result 2. CLZ 32'h0000_0001 -> 4 cycles, result 31.
